// File: rtl/ddr_rw_scheduler_if.sv
// rtl/ddr_rw_scheduler_if.sv - Burst request/issue bundle between rd/wr arbiters, scheduler and AXI masters
//
// Signals
//  rd_req/rd_addr, wr_req/wr_addr : level requests from the read/write arbiters, held until ack
//  rd_done, wr_done               : 1-cycle burst-complete pulses from the AXI read/write masters
//  rd_start, wr_start             : 1-cycle start pulses to the AXI read/write masters
//  start_addr                     : address of the issued burst
//  rd_ack, wr_ack                 : 1-cycle accept back to the arbiters
//  dir                            : direction of last/current burst (0 read, 1 write)
//  busy                           : scheduler not idle
// Modports
//  master : upstream/downstream environment (drives requests and dones)
//  slave  : the scheduler
interface ddr_rw_scheduler_if #(
    parameter int ADDR_W = 30
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_done;
    logic              wr_done;
    logic              rd_start;
    logic              wr_start;
    logic [ADDR_W-1:0] start_addr;
    logic              rd_ack;
    logic              wr_ack;
    logic              dir;
    logic              busy;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, rd_done, wr_done,
        input  rd_start, wr_start, start_addr, rd_ack, wr_ack, dir, busy
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, rd_done, wr_done,
        output rd_start, wr_start, start_addr, rd_ack, wr_ack, dir, busy
    );
endinterface

// File: rtl/ddr_rw_scheduler.sv
// rtl/ddr_rw_scheduler.sv - Read/write burst scheduler sharing one DDR3 controller
//
// Batches same-direction bursts to limit bus turnaround, inserts TURN_CYC idle cycles
// on a direction change, and bounds starvation of the waiting direction.
// Ports
//  clk    : clock
//  rst_n  : asynchronous, active-low reset
//  bus    : ddr_rw_scheduler_if.slave (requests, dones in; starts, acks, start_addr, dir, busy out)
// Parameters
//  ADDR_W     : burst start address width
//  MAX_BATCH  : max consecutive same-direction bursts while the other direction waits
//  STARVE_LIM : waiting cycles of the other direction that force a switch at the next done
//  TURN_CYC   : idle cycles inserted on a read<->write switch
module ddr_rw_scheduler #(
    parameter int ADDR_W     = 30,
    parameter int MAX_BATCH  = 4,
    parameter int STARVE_LIM = 64,
    parameter int TURN_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ddr_rw_scheduler_if.slave bus
);
    localparam int BW = $clog2(MAX_BATCH + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [BW-1:0] BATCH_MAX  = BW'(MAX_BATCH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYC - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        TURN  = 4'b1000
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [BW-1:0]     batch_cnt_q, batch_cnt_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [TW-1:0]     turn_cnt_q, turn_cnt_d;
    logic              hist_q, hist_d;

    logic              same_req;
    logic              other_req;
    logic              dir_done;
    logic              pick;
    logic              issuing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            start_addr_q <= '0;
            batch_cnt_q  <= '0;
            starve_cnt_q <= '0;
            turn_cnt_q   <= '0;
            hist_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            start_addr_q <= start_addr_d;
            batch_cnt_q  <= batch_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            turn_cnt_q   <= turn_cnt_d;
            hist_q       <= hist_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        start_addr_d = start_addr_q;
        batch_cnt_d  = batch_cnt_q;
        starve_cnt_d = starve_cnt_q;
        turn_cnt_d   = turn_cnt_q;
        hist_d       = hist_q;
        pick         = dir_q;

        same_req  = dir_q ? bus.wr_req  : bus.rd_req;
        other_req = dir_q ? bus.rd_req  : bus.wr_req;
        dir_done  = dir_q ? bus.wr_done : bus.rd_done;

        // Waiting time of the other direction accrues only while a burst is in flight.
        if ((state_q == ISSUE || state_q == WAIT) && other_req && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                starve_cnt_d = '0;
                if (bus.rd_req || bus.wr_req) begin
                    // Both pending: stay in the current direction to avoid a turnaround.
                    pick  = (bus.rd_req && bus.wr_req) ? dir_q : bus.wr_req;
                    dir_d = pick;
                    // Before the first burst there is no bus history, so no gap is needed.
                    if (pick != dir_q && hist_q) begin
                        state_d    = TURN;
                        turn_cnt_d = '0;
                    end else begin
                        state_d      = ISSUE;
                        start_addr_d = pick ? bus.wr_addr : bus.rd_addr;
                    end
                end
            end
            ISSUE: begin
                if (batch_cnt_q != BATCH_MAX) begin
                    batch_cnt_d = batch_cnt_q + 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                // Done of the opposite direction has no burst in flight and is ignored.
                if (dir_done) begin
                    hist_d = 1'b1;
                    if (same_req && !other_req) begin
                        state_d      = ISSUE;
                        batch_cnt_d  = '0;
                        start_addr_d = dir_q ? bus.wr_addr : bus.rd_addr;
                    end else if (same_req && batch_cnt_q < BATCH_MAX && starve_cnt_q < STARVE_MAX) begin
                        state_d      = ISSUE;
                        start_addr_d = dir_q ? bus.wr_addr : bus.rd_addr;
                    end else if (other_req) begin
                        state_d      = TURN;
                        dir_d        = ~dir_q;
                        batch_cnt_d  = '0;
                        starve_cnt_d = '0;
                        turn_cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    if (same_req) begin
                        state_d      = ISSUE;
                        start_addr_d = dir_q ? bus.wr_addr : bus.rd_addr;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign issuing        = (state_q == ISSUE);
    assign bus.rd_start   = issuing & ~dir_q;
    assign bus.wr_start   = issuing &  dir_q;
    assign bus.rd_ack     = issuing & ~dir_q;
    assign bus.wr_ack     = issuing &  dir_q;
    assign bus.start_addr = start_addr_q;
    assign bus.dir        = dir_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
